switch_allocator: RTL
=====================

# switch_allocator

- Centralised output-port allocator for the 5-channel router.
- Takes each RX unit's switch request and target output channel, and grants each TX output to at most one RX input using per-output round-robin.
- Drives the TX switch handshake and the crossbar select/active signals that steer RX buffer data/address to the TX.
- Replaces the per-output arbiter instances and the ack/req fan-in/fan-out glue in the router top.

## Interface
Parameters:
- CHANNELS, 5, number of RX inputs and TX outputs
- CHANNEL_BITS, 3, width of a channel index; must satisfy 2^CHANNEL_BITS >= CHANNELS
- TIMEOUT, 64, cycles a granted TX may take to acknowledge (used only with the timeout feature)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- rx_req  in  CHANNELS  per-input switch request from RX
- rx_chnl  in  CHANNELS*CHANNEL_BITS  target output of input i at bits [i*CHANNEL_BITS +: CHANNEL_BITS]
- rx_gnt  out  CHANNELS  per-input completion ack to RX
- tx_req  out  CHANNELS  per-output switch request to TX
- tx_ack  in  CHANNELS  per-output done/ack from TX
- selected  out  CHANNELS*CHANNEL_BITS  input currently connected to output o, at bits [o*CHANNEL_BITS +: CHANNEL_BITS]
- active  out  CHANNELS  output o holds a valid connection
- timeout_flag  out  CHANNELS  sticky per-output timeout indicator

## Operation
- One independent FSM per output o, with states IDLE, BUSY, DONE.
- Candidate set for output o: inputs i with rx_req[i]=1 and rx_chnl[i]==o.
  - Inputs with rx_chnl >= CHANNELS are never granted.
  - Each input targets one output, so no input is ever in two connections.
- IDLE:
  - If the candidate set is non-empty, pick the first candidate at or after ptr[o], scanning upward with wrap modulo CHANNELS.
  - Next edge: selected[o]<=winner, active[o]<=1, tx_req[o]<=1, go to BUSY.
- BUSY: on tx_ack[o]=1, tx_req[o]<=0 and rx_gnt[winner]<=1, go to DONE.
- DONE:
  - Wait until rx_req[selected]=0 and tx_ack[o]=0.
  - Then rx_gnt<=0, active[o]<=0, ptr[o]<=(selected+1) mod CHANNELS (no wider arithmetic), go to IDLE.
- RX must hold rx_req and rx_chnl stable from assertion until it sees rx_gnt. Changing them in BUSY is a protocol violation; the allocator keeps the latched selected value.
- rx_gnt[i] is the OR over outputs of "output o in DONE and selected[o]==i". At most one term is ever true.
- Simultaneous requests to one output: only the round-robin winner is served; the others stay pending with no lost requests.
- Simultaneous requests to different outputs are granted in the same cycle.
- While active[o]=0, selected[o] holds its last value; the crossbar must qualify it with active.

## Timing
- Reset values: rx_gnt=0, tx_req=0, active=0, selected=0, timeout_flag=0, all ptr=0, all FSMs IDLE.
- Reset asserted mid-operation aborts every connection within the same edge.
- Request to tx_req: 1 cycle (registered; request seen at edge n, tx_req high after edge n+1).
- tx_ack to rx_gnt: 1 cycle. tx_ack to tx_req low: 1 cycle.
- Release (rx_req low and tx_ack low) to active low: 1 cycle.
- Minimum of 1 IDLE cycle between consecutive connections on one output.
- Minimum connection length is 3 cycles of active.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: SWITCH_ALLOC_TIMEOUT_EN.
- When defined:
  - A per-output counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT-1 without tx_ack, the next edge sets tx_req[o]=0, active[o]=0 and timeout_flag[o]=1 (sticky until reset).
  - ptr[o] advances past the stalled input, the FSM returns to IDLE, and rx_gnt is not asserted.
- When undefined:
  - No counter logic is built and timeout_flag is tied to 0.
  - BUSY waits indefinitely; the TIMEOUT parameter is ignored.

## Structure
- Shared package router_pkg holds CHANNELS, CHANNEL_BITS, and the allocator state enum (IDLE, BUSY, DONE). The router top also uses router_pkg for array widths.
- Sub-module rr_pick: combinational round-robin picker, instantiated once per output.
  - Inputs: CHANNELS-bit request vector and ptr.
  - Outputs: winner index and valid.
- Per-output FSM, pointer and timeout counter live in a generate loop in switch_allocator.

## Test plan
- Reset: hold reset=0 for 3 cycles with arbitrary inputs -> all outputs 0; after release with no requests, outputs stay 0.
- Single request: rx_req[2]=1, rx_chnl[2]=4 -> tx_req[4]=1 and active[4]=1 one cycle later with selected[4]=2; tx_ack[4]=1 -> rx_gnt[2]=1 next cycle; drop rx_req[2] and tx_ack[4] -> active[4]=0 next cycle.
- Contention and fairness: inputs 0, 1 and 3 all target output 1 and re-request immediately after each release -> grant order 0, 1, 3, 0; no input served twice before the others.
- Parallel connections: input 0 to output 2 and input 4 to output 0 together -> tx_req[2] and tx_req[0] rise in the same cycle; selected correct; no cross-talk on rx_gnt.
- Boundary cases: rx_chnl=7 with CHANNELS=5 -> never granted; with ptr[o]=4 and requests on inputs 1 and 4 -> input 4 wins, next winner input 1 (wrap).
- Reset mid-connection and timeout: assert reset=0 during BUSY -> everything cleared next edge. With SWITCH_ALLOC_TIMEOUT_EN and TIMEOUT=8, hold tx_ack=0 -> tx_req and active drop after 8 BUSY cycles, timeout_flag[o]=1 and stays 1 until reset.

Source files
------------

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared constants and allocator state encoding for the
//                5-channel router.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Number of RX inputs / TX outputs and the width of a channel index.
    localparam int CHANNELS     = 5;
    localparam int CHANNEL_BITS = 3;

    // Per-output allocator state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/switch_allocator_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request at or after ptr_i, scanning upward with wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import router_pkg::*;
#(
    parameter int CHANNELS     = router_pkg::CHANNELS,
    parameter int CHANNEL_BITS = router_pkg::CHANNEL_BITS
) (
    input  logic [CHANNELS-1:0]     req_i,
    input  logic [CHANNEL_BITS-1:0] ptr_i,
    output logic [CHANNEL_BITS-1:0] winner_o,
    output logic                    valid_o
);

    logic [CHANNEL_BITS-1:0] hi_idx;
    logic                    hi_vld;
    logic [CHANNEL_BITS-1:0] lo_idx;
    logic                    lo_vld;

    // Lowest request at or above the pointer, and lowest request overall (wrap case).
    always_comb begin
        hi_idx = '0;
        hi_vld = 1'b0;
        lo_idx = '0;
        lo_vld = 1'b0;
        for (int p = CHANNELS - 1; p >= 0; p--) begin
            if (req_i[p]) begin
                lo_idx = CHANNEL_BITS'(p);
                lo_vld = 1'b1;
                if (CHANNEL_BITS'(p) >= ptr_i) begin
                    hi_idx = CHANNEL_BITS'(p);
                    hi_vld = 1'b1;
                end
            end
        end
    end

    assign winner_o = hi_vld ? hi_idx : lo_idx;
    assign valid_o  = lo_vld;

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Centralised output-port allocator. Each TX output runs an
//                independent IDLE/BUSY/DONE FSM with a round-robin pointer,
//                drives the TX switch handshake and the crossbar select.
//                Optional per-output BUSY timeout: SWITCH_ALLOC_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
    import router_pkg::*;
#(
    parameter int CHANNELS     = router_pkg::CHANNELS,
    parameter int CHANNEL_BITS = router_pkg::CHANNEL_BITS,
    parameter int TIMEOUT      = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              rx_req,
    input  logic [CHANNELS*CHANNEL_BITS-1:0] rx_chnl,
    output logic [CHANNELS-1:0]              rx_gnt,
    output logic [CHANNELS-1:0]              tx_req,
    input  logic [CHANNELS-1:0]              tx_ack,
    output logic [CHANNELS*CHANNEL_BITS-1:0] selected,
    output logic [CHANNELS-1:0]              active,
    output logic [CHANNELS-1:0]              timeout_flag
);

    localparam logic [CHANNEL_BITS-1:0] LAST_CHNL = CHANNEL_BITS'(CHANNELS - 1);

    logic [CHANNELS-1:0]              rx_gnt_q;
    logic [CHANNELS-1:0]              rx_gnt_d;
    logic [CHANNELS-1:0]              done_d;
    logic [CHANNELS*CHANNEL_BITS-1:0] sel_d_all;

`ifndef SWITCH_ALLOC_TIMEOUT_EN
    // Timeout depth has no meaning without the counter.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
`endif

    for (genvar o = 0; o < CHANNELS; o++) begin : g_out
        localparam logic [CHANNEL_BITS-1:0] OUT_IDX = CHANNEL_BITS'(o);

        logic [CHANNELS-1:0]     cand;
        logic [CHANNEL_BITS-1:0] win;
        logic                    win_vld;
        alloc_state_t            state_q;
        alloc_state_t            state_d;
        logic [CHANNEL_BITS-1:0] sel_q;
        logic [CHANNEL_BITS-1:0] sel_d;
        logic [CHANNEL_BITS-1:0] ptr_q;
        logic [CHANNEL_BITS-1:0] ptr_d;
        logic [CHANNEL_BITS-1:0] sel_inc;
        logic                    tx_req_q;
        logic                    tx_req_d;
        logic                    active_q;
        logic                    active_d;
        logic                    expired;

        // Inputs requesting this output; out-of-range targets never match.
        always_comb begin
            cand = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cand[i] = rx_req[i] &&
                          (rx_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] == OUT_IDX);
            end
        end

        rr_pick #(
            .CHANNELS     (CHANNELS),
            .CHANNEL_BITS (CHANNEL_BITS)
        ) u_pick (
            .req_i    (cand),
            .ptr_i    (ptr_q),
            .winner_o (win),
            .valid_o  (win_vld)
        );

        // Pointer value that places the just-served input last in priority.
        assign sel_inc = (sel_q == LAST_CHNL) ? '0 : sel_q + 1'b1;

`ifdef SWITCH_ALLOC_TIMEOUT_EN
        localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             tflag_q;
        logic             tflag_d;

        // Counter runs only while BUSY, so it is zero on every BUSY entry.
        assign expired = (cnt_q == CNT_LAST);
        assign cnt_d   = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
        assign tflag_d = tflag_q | ((state_q == BUSY) && !tx_ack[o] && expired);

        // Timeout counter and sticky flag.
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_q   <= '0;
                tflag_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                tflag_q <= tflag_d;
            end
        end

        assign timeout_flag[o] = tflag_q;
`else
        assign expired         = 1'b0;
        assign timeout_flag[o] = 1'b0;
`endif

        // Next-state and registered-output decode for this output.
        always_comb begin
            state_d  = state_q;
            sel_d    = sel_q;
            ptr_d    = ptr_q;
            tx_req_d = tx_req_q;
            active_d = active_q;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_d  = BUSY;
                        sel_d    = win;
                        tx_req_d = 1'b1;
                        active_d = 1'b1;
                    end
                end
                BUSY: begin
                    if (tx_ack[o]) begin
                        state_d  = DONE;
                        tx_req_d = 1'b0;
                    end else if (expired) begin
                        state_d  = IDLE;
                        tx_req_d = 1'b0;
                        active_d = 1'b0;
                        ptr_d    = sel_inc;
                    end
                end
                DONE: begin
                    if (!rx_req[sel_q] && !tx_ack[o]) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                        ptr_d    = sel_inc;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    tx_req_d = 1'b0;
                    active_d = 1'b0;
                end
            endcase
        end

        // State, selection, pointer and handshake registers.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q  <= IDLE;
                sel_q    <= '0;
                ptr_q    <= '0;
                tx_req_q <= 1'b0;
                active_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                sel_q    <= sel_d;
                ptr_q    <= ptr_d;
                tx_req_q <= tx_req_d;
                active_q <= active_d;
            end
        end

        assign tx_req[o]                                  = tx_req_q;
        assign active[o]                                  = active_q;
        assign selected[o*CHANNEL_BITS +: CHANNEL_BITS]   = sel_q;
        assign done_d[o]                                  = (state_d == DONE);
        assign sel_d_all[o*CHANNEL_BITS +: CHANNEL_BITS]  = sel_d;
    end

    // Grant to an input is high while the output it holds sits in DONE.
    always_comb begin
        rx_gnt_d = '0;
        for (int o = 0; o < CHANNELS; o++) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (done_d[o] &&
                    (sel_d_all[o*CHANNEL_BITS +: CHANNEL_BITS] == CHANNEL_BITS'(i))) begin
                    rx_gnt_d[i] = 1'b1;
                end
            end
        end
    end

    // Registered grant vector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_gnt_q <= '0;
        end else begin
            rx_gnt_q <= rx_gnt_d;
        end
    end

    assign rx_gnt = rx_gnt_q;

endmodule
`default_nettype wire
